branch_predictor: RTL and testbench

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

---
 rtl/branch_predictor.sv | 136 +++++++++++++
 tb/tb_branch_predictor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Gshare/bimodal direction predictor: a table of saturating counters indexed by PC
// (optionally XORed with global history), with a registered lookup and a clear sweep.
module branch_predictor #(
    parameter int ENTRIES   = 64,
    parameter int CTR_W     = 2,
    parameter int GHR_W     = 6,
    parameter int GSHARE    = 1,
    parameter int RESET_CTR = (2 ** (CTR_W - 1)) - 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        lookup_valid_i,
    input  logic [31:0]                 lookup_pc_i,
    output logic                        pred_valid_o,
    output logic                        pred_taken_o,
    output logic [$clog2(ENTRIES)-1:0]  pred_index_o,
    input  logic                        update_valid_i,
    input  logic [$clog2(ENTRIES)-1:0]  update_index_i,
    input  logic                        update_taken_i,
    input  logic                        clear_i,
    output logic                        ready_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam logic [CTR_W-1:0] CTR_MAX   = '1;
    localparam logic [CTR_W-1:0] RESET_VAL = CTR_W'(RESET_CTR);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(ENTRIES - 1);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t             state;
    state_t             next_state;
    logic [CTR_W-1:0]   ctr_table [ENTRIES];
    logic [GHR_W-1:0]   ghr;
    logic [IDX_W-1:0]   sweep_ptr;
    logic [IDX_W-1:0]   pc_bits;
    logic [IDX_W-1:0]   lookup_index;
    logic [CTR_W-1:0]   cur_ctr;
    logic [CTR_W-1:0]   next_ctr;
    logic               start_sweep;
    logic               lookup_accept;
    logic               update_accept;
    logic               unused_pc_bits;

    assign pc_bits        = lookup_pc_i[IDX_W+1:2];
    assign unused_pc_bits = ^{lookup_pc_i[31:IDX_W+2], lookup_pc_i[1:0]};

    generate
        if (GSHARE != 0) begin : g_gshare
            assign lookup_index = pc_bits ^ IDX_W'(ghr);
        end else begin : g_bimodal
            assign lookup_index = pc_bits;
        end
    endgenerate

    // A clear pulse wins over any lookup or update presented in the same cycle.
    assign ready_o       = (state == IDLE);
    assign start_sweep   = ready_o && clear_i;
    assign lookup_accept = ready_o && lookup_valid_i && !clear_i;
    assign update_accept = ready_o && update_valid_i && !clear_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clear_i) next_state = SWEEP;
            SWEEP:   if (sweep_ptr == LAST_IDX) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        cur_ctr  = ctr_table[update_index_i];
        next_ctr = cur_ctr;
        if (update_taken_i) begin
            if (cur_ctr != CTR_MAX) next_ctr = cur_ctr + 1'b1;
        end else begin
            if (cur_ctr != '0) next_ctr = cur_ctr - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_table[i] <= RESET_VAL;
            end
        end else if (state == SWEEP) begin
            ctr_table[sweep_ptr] <= RESET_VAL;
        end else if (update_accept) begin
            ctr_table[update_index_i] <= next_ctr;
        end
    end

    // History is non-speculative: it only moves on resolved updates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr       <= '0;
            sweep_ptr <= '0;
        end else if (start_sweep) begin
            ghr       <= '0;
            sweep_ptr <= '0;
        end else if (state == SWEEP) begin
            sweep_ptr <= sweep_ptr + 1'b1;
        end else if (update_accept) begin
            ghr <= (ghr << 1) | GHR_W'(update_taken_i);
        end
    end

    // Lookup reads the pre-update counter; no bypass from a same-cycle update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_index_o <= '0;
        end else if (lookup_accept) begin
            pred_valid_o <= 1'b1;
            pred_taken_o <= ctr_table[lookup_index][CTR_W-1];
            pred_index_o <= lookup_index;
        end else begin
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
            pred_index_o <= '0;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor at default parameters: vector table,
// scoreboard of expected predictions, and clear-sweep / reset-abort sequences.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        lookup_valid_i;
    logic [31:0] lookup_pc_i;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic [5:0]  pred_index_o;
    logic        update_valid_i;
    logic [5:0]  update_index_i;
    logic        update_taken_i;
    logic        clear_i;
    logic        ready_o;

    typedef struct {
        logic        lv;
        logic        tgt;
        logic [31:0] pc;
        logic        uv;
        logic [5:0]  uidx;
        logic        ut;
        logic        ev;
        logic        et;
        logic [5:0]  ei;
    } vec_t;

    typedef struct {
        logic       ev;
        logic       et;
        logic [5:0] ei;
    } exp_t;

    int         n_checks = 0;
    int         n_fails  = 0;
    logic [5:0] ghr_m;
    exp_t       sb[$];
    vec_t       vecs[$];

    branch_predictor dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lookup_valid_i (lookup_valid_i),
        .lookup_pc_i    (lookup_pc_i),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .pred_index_o   (pred_index_o),
        .update_valid_i (update_valid_i),
        .update_index_i (update_index_i),
        .update_taken_i (update_taken_i),
        .clear_i        (clear_i),
        .ready_o        (ready_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, queue its expected prediction, then compare after the edge.
    task automatic applyStimulus(input logic lv, input logic [31:0] pc, input logic uv,
                                 input logic [5:0] uidx, input logic ut, input logic clr,
                                 input exp_t e, input string name);
        exp_t got;
        lookup_valid_i = lv;
        lookup_pc_i    = pc;
        update_valid_i = uv;
        update_index_i = uidx;
        update_taken_i = ut;
        clear_i        = clr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        checkOutput({name, " pred_valid"}, 32'(pred_valid_o), 32'(got.ev));
        checkOutput({name, " pred_taken"}, 32'(pred_taken_o), 32'(got.et));
        checkOutput({name, " pred_index"}, 32'(pred_index_o), 32'(got.ei));
    endtask

    function automatic logic [31:0] pc_for(input logic [5:0] tgt);
        return {24'h123456, tgt ^ ghr_m, 2'b01};
    endfunction

    function automatic vec_t mk(input logic lv, input logic tgt, input logic [31:0] pc,
                                input logic uv, input logic [5:0] uidx, input logic ut,
                                input logic ev, input logic et, input logic [5:0] ei);
        vec_t v;
        v.lv = lv; v.tgt = tgt; v.pc = pc; v.uv = uv; v.uidx = uidx; v.ut = ut;
        v.ev = ev; v.et = et; v.ei = ei;
        return v;
    endfunction

    // Every entry must read as 1: not taken before a taken update, taken after it.
    task automatic read_back(input string tag);
        exp_t e;
        for (int i = 0; i < 64; i++) begin
            e = '{1'b1, 1'b0, 6'(i)};
            applyStimulus(1'b1, pc_for(6'(i)), 1'b1, 6'(i), 1'b1, 1'b0, e, $sformatf("%s_pre%0d", tag, i));
            ghr_m = {ghr_m[4:0], 1'b1};
            e = '{1'b1, 1'b1, 6'(i)};
            applyStimulus(1'b1, pc_for(6'(i)), 1'b0, 6'd0, 1'b0, 1'b0, e, $sformatf("%s_post%0d", tag, i));
        end
    endtask

    task automatic run_sweep(input int extra_at, input int abort_at, input string tag);
        exp_t e;
        int   cnt;
        e = '{1'b0, 1'b0, 6'd0};
        applyStimulus(1'b1, 32'h40, 1'b1, 6'd9, 1'b1, 1'b1, e, {tag, "_clr"});
        ghr_m = '0;
        cnt = 0;
        while (ready_o === 1'b0 && cnt < 200) begin
            if (cnt == abort_at) begin
                lookup_valid_i = 1'b0;
                update_valid_i = 1'b0;
                clear_i        = 1'b0;
                #2 rst_n = 1'b0;
                #1;
                checkOutput({tag, " abort ready"}, 32'(ready_o), 32'd1);
                checkOutput({tag, " abort pred_valid"}, 32'(pred_valid_o), 32'd0);
                checkOutput({tag, " abort pred_index"}, 32'(pred_index_o), 32'd0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            applyStimulus(1'b1, $urandom, 1'b1, 6'(cnt), 1'b1, 1'(cnt == extra_at), e,
                          $sformatf("%s_sw%0d", tag, cnt));
            cnt++;
        end
        checkOutput({tag, " sweep_len"}, 32'(cnt), 32'd64);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        exp_t  e;
        vec_t  v;
        logic [31:0] pc;

        vecs.push_back(mk(1, 0, 32'h40,       0,  0, 0, 1, 0, 16));
        vecs.push_back(mk(0, 0, 0,            1, 16, 1, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0,            1, 16, 1, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0,            1, 16, 1, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0,            1, 16, 1, 0, 0,  0));
        vecs.push_back(mk(1, 0, 32'h40,       0,  0, 0, 1, 0, 31));
        vecs.push_back(mk(1, 0, 32'hFFFFFF7F, 0,  0, 0, 1, 1, 16));
        vecs.push_back(mk(0, 0, 0,            1, 16, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, 16,           0,  0, 0, 1, 1, 16));
        vecs.push_back(mk(0, 0, 0,            1, 16, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, 16,           0,  0, 0, 1, 0, 16));
        vecs.push_back(mk(0, 0, 0,            1, 40, 1, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0,            1, 40, 1, 0, 0,  0));
        vecs.push_back(mk(1, 1, 40,           0,  0, 0, 1, 1, 40));
        vecs.push_back(mk(0, 0, 0,            1, 40, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, 40,           0,  0, 0, 1, 1, 40));
        vecs.push_back(mk(0, 0, 0,            1, 40, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0,            1, 40, 0, 0, 0,  0));
        vecs.push_back(mk(0, 0, 0,            1, 40, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, 40,           0,  0, 0, 1, 0, 40));
        vecs.push_back(mk(0, 0, 0,            1, 40, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, 40,           0,  0, 0, 1, 0, 40));
        vecs.push_back(mk(0, 0, 0,            1, 40, 1, 0, 0,  0));
        vecs.push_back(mk(1, 1, 40,           0,  0, 0, 1, 0, 40));
        vecs.push_back(mk(1, 1, 5,            1,  5, 1, 1, 0,  5));
        vecs.push_back(mk(1, 1, 5,            0,  0, 0, 1, 1,  5));
        vecs.push_back(mk(0, 0, 0,            0,  0, 0, 0, 0,  0));
        vecs.push_back(mk(1, 1, 5,            1,  7, 0, 1, 1,  5));

        rst_n          = 1'b0;
        lookup_valid_i = 1'b0;
        lookup_pc_i    = '0;
        update_valid_i = 1'b0;
        update_index_i = '0;
        update_taken_i = 1'b0;
        clear_i        = 1'b0;
        ghr_m          = '0;
        #1;
        checkOutput("reset ready", 32'(ready_o), 32'd1);
        checkOutput("reset pred_valid", 32'(pred_valid_o), 32'd0);
        checkOutput("reset pred_taken", 32'(pred_taken_o), 32'd0);
        checkOutput("reset pred_index", 32'(pred_index_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            v  = vecs[i];
            pc = v.tgt ? pc_for(v.pc[5:0]) : v.pc;
            e  = '{v.ev, v.et, v.ei};
            applyStimulus(v.lv, pc, v.uv, v.uidx, v.ut, 1'b0, e, $sformatf("vec%0d", i));
            if (v.uv) ghr_m = {ghr_m[4:0], v.ut};
        end

        run_sweep(-1, -1, "sweep1");
        read_back("rb1");
        run_sweep(30, -1, "sweep2");
        read_back("rb2");
        run_sweep(-1, 20, "abort");
        ghr_m = '0;
        read_back("rb3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
